// File: rtl/key_entry_pkg.sv
// Shared types and constants for the hex key-entry display.
// Holds the controller state encoding and the seven-segment glyph table.
package key_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  localparam logic [6:0] BLANK = 7'h00;

  // Entry n is the segment pattern (g..a) for hex digit n.
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-seven-segment decoder with blanking enable.
module hex7seg
  import key_entry_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       en_i,
  output logic [6:0] seg_o
);

  assign seg_o = en_i ? GLYPH[hex_i] : BLANK;

endmodule

// File: rtl/key_entry_display.sv
// Debounced hex keypad entry with backspace/clear and a multi-digit 7-segment readout.
// Buttons are synchronized, debounced as one group, and commit exactly one action per press.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no button seen; waiting for any synchronized button
// DEBOUNCE | button seen; counting stable cycles before committing
// HELD     | action committed; waiting for all buttons to be released
module key_entry_display
  import key_entry_pkg::*;
#(
  parameter int N_KEYS     = 16,
  parameter int N_DIGITS   = 8,
  parameter int DEB_CYCLES = 2
) (
  input  logic                              hz100,
  input  logic                              reset,
  input  logic [N_KEYS-1:0]                 pb,
  input  logic                              bksp,
  input  logic                              clr,
  output logic [8*N_DIGITS-1:0]             ss,
  output logic [4*N_DIGITS-1:0]             value,
  output logic [$clog2(N_DIGITS+1)-1:0]     count,
  output logic                              keystrobe,
  output logic                              overflow
);

  localparam int VW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = N_KEYS + 2;

  localparam logic [CW-1:0] FULL     = CW'(N_DIGITS);
  localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYCLES - 1);

  logic [SW-1:0]  sync1_q, sync2_q;
  state_e         state_q, state_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic [VW-1:0]  value_q, value_d;
  logic [CW-1:0]  count_q, count_d;
  logic           keystrobe_q, keystrobe_d;
  logic           overflow_q, overflow_d;

  logic              any_key;
  logic              commit;
  logic [N_KEYS-1:0] pb_s;
  logic              bksp_s, clr_s;
  logic [3:0]        digit_idx;

  function automatic logic [3:0] highest_idx(input logic [N_KEYS-1:0] p);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (p[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Two-flop synchronizer for every button, packed as {clr, bksp, pb}.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {clr, bksp, pb};
      sync2_q <= sync1_q;
    end
  end

  assign pb_s      = sync2_q[N_KEYS-1:0];
  assign bksp_s    = sync2_q[N_KEYS];
  assign clr_s     = sync2_q[N_KEYS+1];
  assign any_key   = |sync2_q;
  assign digit_idx = highest_idx(pb_s);

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stability counter runs down to terminal count zero, then commits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_key) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = DEB_LOAD;
        end
      end
      ST_DEBOUNCE: begin
        if (!any_key) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      ST_HELD: begin
        if (!any_key) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Action datapath; priority is clr, then bksp, then the highest digit.
  always_comb begin
    value_d     = value_q;
    count_d     = count_q;
    keystrobe_d = 1'b0;
    overflow_d  = 1'b0;
    if (commit) begin
      keystrobe_d = 1'b1;
      if (clr_s) begin
        value_d = '0;
        count_d = '0;
      end else if (bksp_s) begin
        if (count_q != '0) begin
          value_d = value_q >> 4;
          count_d = count_q - CW'(1);
        end
      end else if (count_q == FULL) begin
        overflow_d = 1'b1;
      end else begin
        value_d = (value_q << 4) | VW'(digit_idx);
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      value_q     <= '0;
      count_q     <= '0;
      keystrobe_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      value_q     <= value_d;
      count_q     <= count_d;
      keystrobe_q <= keystrobe_d;
      overflow_q  <= overflow_d;
    end
  end

  assign value     = value_q;
  assign count     = count_q;
  assign keystrobe = keystrobe_q;
  assign overflow  = overflow_q;

  // Digit 0 always shows "0" on an empty entry so the display never goes dark.
  for (genvar d = 0; d < N_DIGITS; d++) begin : g_dig
    logic       en;
    logic [6:0] seg;
    assign en = (count_q > CW'(d)) || ((d == 0) && (count_q == '0));
    hex7seg u_hex7seg (
      .hex_i (value_q[4*d +: 4]),
      .en_i  (en),
      .seg_o (seg)
    );
    assign ss[8*d +: 8] = {1'b0, seg};
  end

endmodule

// File: tb/tb_key_entry_display.sv
// Scoreboard bench for key_entry_display: stimulus queues expected commits,
// a negedge monitor checks each keystrobe against the queue.
module tb_key_entry_display;

  localparam int DEB = 2;

  logic        hz100 = 1'b0;
  logic        reset;
  logic [15:0] pb;
  logic        bksp, clr;
  logic [63:0] ss;
  logic [31:0] value;
  logic [3:0]  count;
  logic        keystrobe, overflow;

  typedef struct {
    logic [31:0] v;
    logic [3:0]  c;
    logic        o;
    logic [63:0] s;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_fail = 0, cyc = 0, n_strobe = 0, n_push = 0;

  key_entry_display #(.N_KEYS(16), .N_DIGITS(8), .DEB_CYCLES(DEB)) dut (
    .hz100     (hz100),
    .reset     (reset),
    .pb        (pb),
    .bksp      (bksp),
    .clr       (clr),
    .ss        (ss),
    .value     (value),
    .count     (count),
    .keystrobe (keystrobe),
    .overflow  (overflow)
  );

  always #5 hz100 = ~hz100;

  initial forever begin
    @(posedge hz100);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every keystrobe must match the oldest queued expectation.
  always @(negedge hz100) begin
    if (keystrobe === 1'b1) begin
      n_strobe++;
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_keystrobe: got strobe at cycle %0d want none", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("value", 64'(value), 64'(mon_e.v));
        chk("count", 64'(count), 64'(mon_e.c));
        chk("overflow", 64'(overflow), 64'(mon_e.o));
        chk("ss", ss, mon_e.s);
        if (mon_e.cyc >= 0) chk("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end else if (overflow === 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL overflow_no_strobe: got overflow=1 want 0 at cycle %0d", cyc);
    end
  end

  function automatic logic [15:0] key(input int i);
    logic [15:0] one;
    one = 16'd1;
    return one << i;
  endfunction

  task automatic push_exp(input logic [31:0] ev, input logic [3:0] ec, input logic eo,
                          input logic [63:0] es, input int ecyc);
    exp_t e;
    e.v = ev; e.c = ec; e.o = eo; e.s = es; e.cyc = ecyc;
    q.push_back(e);
    n_push++;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (q.size() != 0 && i < 30) begin
      @(posedge hz100);
      i++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got %0d pending commits want 0", q.size());
      q.delete();
    end
  endtask

  // Press a combination for 'hold' cycles; commit is due 3+DEB edges after the drive point.
  task automatic act(input logic [15:0] p, input logic b, input logic c, input int hold,
                     input logic [31:0] ev, input logic [3:0] ec, input logic eo,
                     input logic [63:0] es);
    @(posedge hz100); #2;
    push_exp(ev, ec, eo, es, cyc + 3 + DEB);
    pb = p; bksp = b; clr = c;
    repeat (hold) @(posedge hz100);
    #2;
    pb = '0; bksp = 1'b0; clr = 1'b0;
    wait_drain();
    repeat (6) @(posedge hz100);
  endtask

  task automatic chk_reset_state();
    @(negedge hz100);
    chk("rst_value", 64'(value), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_ss", ss, 64'h3F);
    chk("rst_keystrobe", 64'(keystrobe), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
  endtask

  logic [31:0] seq_v  [8];
  logic [63:0] seq_ss [8];

  initial begin
    seq_v  = '{32'h1, 32'h12, 32'h123, 32'h1234, 32'h12345, 32'h123456,
               32'h1234567, 32'h12345678};
    seq_ss = '{64'h06, 64'h065B, 64'h065B4F, 64'h065B4F66, 64'h065B4F666D,
               64'h065B4F666D7D, 64'h065B4F666D7D07, 64'h065B4F666D7D077F};

    reset = 1'b0; pb = '0; bksp = 1'b0; clr = 1'b0;
    repeat (3) @(posedge hz100);
    chk_reset_state();
    @(posedge hz100); #2 reset = 1'b1;
    repeat (3) @(posedge hz100);

    act(key(5), 1'b0, 1'b0, 10, 32'h5, 4'd1, 1'b0, 64'h6D);
    act('0, 1'b0, 1'b1, 6, 32'h0, 4'd0, 1'b0, 64'h3F);
    act(key(1), 1'b0, 1'b0, 6, 32'h1, 4'd1, 1'b0, 64'h06);
    act(key(2), 1'b0, 1'b0, 6, 32'h12, 4'd2, 1'b0, 64'h065B);
    act(key(3), 1'b0, 1'b0, 6, 32'h123, 4'd3, 1'b0, 64'h065B4F);
    act('0, 1'b1, 1'b0, 6, 32'h12, 4'd2, 1'b0, 64'h065B);
    act('0, 1'b0, 1'b1, 6, 32'h0, 4'd0, 1'b0, 64'h3F);
    act('0, 1'b1, 1'b0, 6, 32'h0, 4'd0, 1'b0, 64'h3F);

    for (int i = 0; i < 8; i++)
      act(key(i + 1), 1'b0, 1'b0, 6, seq_v[i], 4'(i + 1), 1'b0, seq_ss[i]);
    act(key(9), 1'b0, 1'b0, 6, 32'h12345678, 4'd8, 1'b1, 64'h065B4F666D7D077F);
    act('0, 1'b1, 1'b0, 6, 32'h01234567, 4'd7, 1'b0, 64'h065B4F666D7D07);

    act(key(3) | key(12), 1'b1, 1'b1, 6, 32'h0, 4'd0, 1'b0, 64'h3F);
    act(key(3) | key(12), 1'b0, 1'b0, 50, 32'hC, 4'd1, 1'b0, 64'h39);

    // One-cycle glitch must not commit.
    @(posedge hz100); #2 pb = key(2);
    @(posedge hz100); #2 pb = '0;
    repeat (12) @(posedge hz100);
    @(negedge hz100);
    chk("glitch_value", 64'(value), 64'hC);

    // Reset while in DEBOUNCE aborts; the still-held key is then a fresh press.
    @(posedge hz100); #2 pb = key(7);
    repeat (3) @(posedge hz100);
    #2 reset = 1'b0;
    chk_reset_state();
    repeat (2) @(posedge hz100);
    #2 reset = 1'b1;
    push_exp(32'h7, 4'd1, 1'b0, 64'h07, cyc + 3 + DEB);
    repeat (10) @(posedge hz100);
    #2 pb = '0;
    wait_drain();
    repeat (10) @(posedge hz100);

    chk("queue_empty", 64'(q.size()), 64'h0);
    chk("strobe_total", 64'(n_strobe), 64'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_entry_display.md
KEY_ENTRY_DISPLAY -- requirements
Module: key_entry_display

Interface
REQ-001 SHALL have parameter N_KEYS, default 16, meaning the number of hex-digit push buttons (1..16); key index i enters digit value i.
REQ-002 SHALL have parameter N_DIGITS, default 8, meaning the number of displayed digits (1..8).
REQ-003 SHALL have parameter DEB_CYCLES, default 2, meaning the number of consecutive stable-press cycles required to accept a key (>=1).
REQ-004 hz100  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pb  in  N_KEYS  digit buttons, active-high, asynchronous to hz100.
REQ-007 bksp  in  1  backspace button, active-high, asynchronous.
REQ-008 clr  in  1  clear button, active-high, asynchronous.
REQ-009 ss  out  8*N_DIGITS  segment bus; byte d drives digit d; bits[6:0]=segments a..g; bit 7 (dp) is always 0.
REQ-010 value  out  4*N_DIGITS  entered number; nibble 0 holds the most recently entered digit.
REQ-011 count  out  clog2(N_DIGITS+1)  number of valid digits, 0..N_DIGITS.
REQ-012 keystrobe  out  1  one-cycle pulse per accepted action.
REQ-013 overflow  out  1  one-cycle pulse when a digit is rejected because count==N_DIGITS.

Function
REQ-014 pb, bksp and clr SHALL each pass through a 2-flop synchronizer; any_key SHALL be the OR of all synchronized buttons.
REQ-015 The control FSM SHALL have states IDLE, DEBOUNCE and HELD.
REQ-016 In IDLE with any_key=1, the FSM SHALL go to DEBOUNCE and load the stability counter.
REQ-017 In DEBOUNCE with any_key=0, the FSM SHALL return to IDLE with no action.
REQ-018 In DEBOUNCE, the FSM SHALL commit one action and go to HELD on the cycle any_key has been 1 for DEB_CYCLES consecutive cycles.
REQ-019 In HELD, the FSM SHALL stay until any_key=0, then go to IDLE; holding keys SHALL never produce a second action.
REQ-020 Commit latency: a button first sampled high at edge k and held stable SHALL update value/count and pulse keystrobe at edge k+2+DEB_CYCLES.
REQ-021 Commit priority: clr SHALL beat bksp, bksp SHALL beat digits, and among digits the highest asserted index SHALL win; the winner is sampled on the commit cycle.
REQ-022 Digit commit with count<N_DIGITS: value SHALL shift left 4 bits, insert the index in nibble 0, and increment count.
REQ-023 Digit commit with count==N_DIGITS: value and count SHALL be unchanged, overflow SHALL pulse, and keystrobe SHALL pulse.
REQ-024 bksp commit with count>0: value SHALL shift right 4 bits with zero fill, and count SHALL decrement.
REQ-025 bksp commit with count==0: value and count SHALL be unchanged, and keystrobe SHALL pulse.
REQ-026 clr commit: value SHALL become 0 and count SHALL become 0.
REQ-027 Display: digit d SHALL show the hex glyph of nibble d when d<count, and SHALL be blank (0x00) otherwise.
REQ-028 Display exception: when count==0, digit 0 SHALL show glyph "0".
REQ-029 ss SHALL be combinational from value/count, with no added latency.
REQ-030 Glyph set: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.

Reset
REQ-031 reset=0 SHALL asynchronously force FSM=IDLE, synchronizers=0, stability counter=0, value=0, count=0, keystrobe=0 and overflow=0; ss SHALL then show "0" on digit 0 and blanks elsewhere.
REQ-032 Reset asserted during DEBOUNCE or HELD SHALL abort the pending action; after release, a still-held key SHALL be accepted as a new press after full sync+debounce.

Structure
REQ-033 Package key_entry_pkg SHALL hold the FSM state enum, the 16-entry glyph table, and the BLANK constant.
REQ-034 Combinational sub-module hex7seg (4-bit in, enable, 7-bit out) SHALL be instantiated N_DIGITS times.

Verification
REQ-035 After reset, press pb[5] for 10 cycles -> keystrobe at edge k+4, value=0x5, count=1, ss byte0=0x6D, bytes1-7=0x00.
REQ-036 Enter 1,2,3 with releases, then bksp -> value=0x12, count=2, ss byte1=0x06, byte0=0x5B.
REQ-037 Enter 8 digits, then press pb[9] -> overflow and keystrobe pulse once, value unchanged, count=8.
REQ-038 Assert pb[3], pb[12], bksp and clr together -> clr wins: value=0, count=0.
REQ-039 Assert pb[3] and pb[12] together -> value nibble0=0xC; hold pb for 50 cycles -> exactly one keystrobe.
REQ-040 Pulse pb[2] high for 1 cycle (shorter than debounce) -> no keystrobe; assert reset mid-DEBOUNCE -> no commit, all outputs at reset values.
